reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 16, number of entries (2..64).
REQ-002 Parameter ISSUE_CNT, default 2, issue ports written per cycle.
REQ-003 Parameter CDB_CNT, default 2, result broadcast buses snooped.
REQ-004 Parameter XLEN, default 32, operand width; RN_W, default 6, register-name width; PAY_W, default 72, opaque payload width (address, imm, pid, rrn).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 iss_valid  in  ISSUE_CNT  per-port issue request selecting this station.
REQ-008 iss_src1/iss_src2  in  ISSUE_CNT*RN_W  source register names.
REQ-009 iss_ok1/iss_ok2  in  ISSUE_CNT  operand already valid.
REQ-010 iss_data1/iss_data2  in  ISSUE_CNT*XLEN  operand values.
REQ-011 iss_tag  in  ISSUE_CNT  speculative (under unresolved branch).
REQ-012 iss_payload  in  ISSUE_CNT*PAY_W  carried unchanged to output.
REQ-013 cdb_valid  in  CDB_CNT; cdb_rn  in  CDB_CNT*RN_W; cdb_data  in  CDB_CNT*XLEN  result broadcasts.
REQ-014 flush  in  1  remove all tagged entries; tag_clear  in  1  branch resolved correct, clear all tags.
REQ-015 out_valid  out  1; out_ready  in  1; out_data1/out_data2  out  XLEN; out_payload  out  PAY_W; out_tag  out  1  dispatch handshake to execution unit.
REQ-016 free_count  out  $clog2(DEPTH+1)  unoccupied entries; overflow  out  1  sticky error.

Function
REQ-017 Entries SHALL be held in arrival order (index 0 oldest); removals SHALL collapse younger entries toward index 0 in the same edge.
REQ-018 Issue ports SHALL be appended in port order (port 0 older) at the rising edge; entry visible to dispatch from the next cycle.
REQ-019 At issue, an operand with ok=0 SHALL capture a same-cycle CDB whose cdb_valid=1, cdb_rn==src and src!=0; lowest CDB index wins on multiple hits; src==0 SHALL be treated as valid with data 0.
REQ-020 Each cycle, every held entry with an invalid operand SHALL capture a matching CDB (same rule) and become valid at that edge.
REQ-021 out_valid SHALL be combinational: asserted when any entry has both operands valid; selected entry is the lowest-index ready one; out_* reflect it.
REQ-022 Dispatch SHALL complete when out_valid && out_ready at an edge; that entry is removed; at most one dispatch per cycle.
REQ-023 Earliest dispatch: issue at edge n, out_valid in cycle n+1; CDB wake-up at edge n, out_valid in cycle n+1.
REQ-024 flush=1: out_valid SHALL be suppressed if the selected entry is tagged (no fallback to untagged in that cycle); all tagged entries SHALL be removed at the edge; all issue requests that cycle SHALL be dropped.
REQ-025 tag_clear=1 (flush=0): all entry tags SHALL be cleared at the edge, including same-cycle issues; flush overrides tag_clear.
REQ-026 Same-edge dispatch and issue SHALL both occur; the dispatched slot SHALL be reusable that edge.
REQ-027 free_count SHALL be registered, equal to DEPTH minus entries after the edge.
REQ-028 Issue exceeding free capacity (counting same-edge dispatch) SHALL drop the excess ports, highest index first, and set overflow until reset.

Reset
REQ-029 reset low SHALL immediately empty the station: out_valid=0, free_count=DEPTH, overflow=0, all tags and valid bits 0; out_data/out_payload=0.
REQ-030 Reset assertion mid-operation SHALL discard all entries; first issue accepted at first rising edge after release.

Verification
REQ-031 Issue A (ok1=ok2=1) port 0, empty station -> out_valid=1 next cycle, out_data1/2 = A's data; out_ready=1 -> free_count returns to 16.
REQ-032 Issue A (src1=5, ok1=0) then B ready; CDB rn=5 data=0xDEAD two cycles later -> B dispatched first, A dispatched after with out_data1=0xDEAD.
REQ-033 Issue with src1=7 ok1=0 while same-cycle cdb_rn=7 data=0x11 -> out_valid next cycle, out_data1=0x11.
REQ-034 Fill 16 entries, issue 2 more with no dispatch -> both dropped, overflow=1, free_count=0.
REQ-035 Entries T1 (tagged), U1, T2 all ready, flush=1 -> out_valid=0 that cycle, next cycle only U1 present, free_count=15.
REQ-036 Reset low while 5 entries held -> out_valid=0 and free_count=16 immediately, without a clock edge.

Source files
------------

// File: rtl/reservation_station_if.sv
// Reservation station bus: issue ports, CDB snoop, branch control,
// dispatch handshake and status. The station itself uses the slave view.
interface reservation_station_if #(
    parameter int DEPTH     = 16,
    parameter int ISSUE_CNT = 2,
    parameter int CDB_CNT   = 2,
    parameter int XLEN      = 32,
    parameter int RN_W      = 6,
    parameter int PAY_W     = 72
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ISSUE_CNT-1:0]       iss_valid;
    logic [ISSUE_CNT*RN_W-1:0]  iss_src1;
    logic [ISSUE_CNT*RN_W-1:0]  iss_src2;
    logic [ISSUE_CNT-1:0]       iss_ok1;
    logic [ISSUE_CNT-1:0]       iss_ok2;
    logic [ISSUE_CNT*XLEN-1:0]  iss_data1;
    logic [ISSUE_CNT*XLEN-1:0]  iss_data2;
    logic [ISSUE_CNT-1:0]       iss_tag;
    logic [ISSUE_CNT*PAY_W-1:0] iss_payload;
    logic [CDB_CNT-1:0]         cdb_valid;
    logic [CDB_CNT*RN_W-1:0]    cdb_rn;
    logic [CDB_CNT*XLEN-1:0]    cdb_data;
    logic                       flush;
    logic                       tag_clear;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_data1;
    logic [XLEN-1:0]            out_data2;
    logic [PAY_W-1:0]           out_payload;
    logic                       out_tag;
    logic [CW-1:0]              free_count;
    logic                       overflow;

    modport master (
        output iss_valid, iss_src1, iss_src2, iss_ok1, iss_ok2, iss_data1, iss_data2,
        output iss_tag, iss_payload, cdb_valid, cdb_rn, cdb_data, flush, tag_clear, out_ready,
        input  out_valid, out_data1, out_data2, out_payload, out_tag, free_count, overflow
    );

    modport slave (
        input  iss_valid, iss_src1, iss_src2, iss_ok1, iss_ok2, iss_data1, iss_data2,
        input  iss_tag, iss_payload, cdb_valid, cdb_rn, cdb_data, flush, tag_clear, out_ready,
        output out_valid, out_data1, out_data2, out_payload, out_tag, free_count, overflow
    );
endinterface

// File: rtl/reservation_station.sv
// Age-ordered reservation station. Entries sit in arrival order (index 0
// oldest), wake up by snooping the CDBs, and the oldest entry with both
// operands valid is offered for dispatch. Removals compact the array in
// the same edge so new issues always append at the current tail.
module reservation_station #(
    parameter int DEPTH     = 16,
    parameter int ISSUE_CNT = 2,
    parameter int CDB_CNT   = 2,
    parameter int XLEN      = 32,
    parameter int RN_W      = 6,
    parameter int PAY_W     = 72
) (
    input logic                  clk,
    input logic                  reset,
    reservation_station_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             tag;
        logic             ok1;
        logic             ok2;
        logic [RN_W-1:0]  src1;
        logic [RN_W-1:0]  src2;
        logic [XLEN-1:0]  data1;
        logic [XLEN-1:0]  data2;
        logic [PAY_W-1:0] payload;
    } entry_t;

    entry_t           ent_reg [DEPTH];
    logic [DEPTH-1:0] occ_reg;
    logic [CW-1:0]    free_count_reg;
    logic             overflow_reg;

    entry_t           woke [DEPTH];
    entry_t           ent_next [DEPTH];
    logic [DEPTH-1:0] occ_next;
    logic [CW-1:0]    count_next;
    logic             overflow_next;
    entry_t           iss_entry;

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             out_valid_int;
    logic             fire;

    // Operand resolution: register 0 is hard-wired valid/zero; otherwise a
    // pending operand takes the lowest-indexed matching CDB broadcast.
    function automatic logic [XLEN:0] capture(
        input logic [RN_W-1:0]         src,
        input logic                    ok,
        input logic [XLEN-1:0]         data,
        input logic [CDB_CNT-1:0]      cv,
        input logic [CDB_CNT*RN_W-1:0] crn,
        input logic [CDB_CNT*XLEN-1:0] cd
    );
        logic [XLEN:0] r;
        r = {ok, data};
        if (src == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end else if (!ok) begin
            for (int c = CDB_CNT - 1; c >= 0; c--) begin
                if (cv[c] && crn[c*RN_W +: RN_W] == src) begin
                    r = {1'b1, cd[c*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        entry_t w;
        // Per-entry CDB snoop: the entry as it will look after this edge.
        always_comb begin
            w = ent_reg[gi];
            {w.ok1, w.data1} = capture(ent_reg[gi].src1, ent_reg[gi].ok1, ent_reg[gi].data1,
                                       bus.cdb_valid, bus.cdb_rn, bus.cdb_data);
            {w.ok2, w.data2} = capture(ent_reg[gi].src2, ent_reg[gi].ok2, ent_reg[gi].data2,
                                       bus.cdb_valid, bus.cdb_rn, bus.cdb_data);
        end
        assign woke[gi] = w;
    end

    // Oldest-ready select over the registered (pre-wake-up) state.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (occ_reg[i] && ent_reg[i].ok1 && ent_reg[i].ok2) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // A flush hides a tagged winner outright rather than falling back.
    assign out_valid_int   = sel_found && !(bus.flush && ent_reg[sel_idx].tag);
    assign fire            = out_valid_int && bus.out_ready;
    assign bus.out_valid   = out_valid_int;
    assign bus.out_data1   = sel_found ? ent_reg[sel_idx].data1   : '0;
    assign bus.out_data2   = sel_found ? ent_reg[sel_idx].data2   : '0;
    assign bus.out_payload = sel_found ? ent_reg[sel_idx].payload : '0;
    assign bus.out_tag     = sel_found ? ent_reg[sel_idx].tag     : 1'b0;
    assign bus.free_count  = free_count_reg;
    assign bus.overflow    = overflow_reg;

    // Next array: compact survivors, append issues in port order, then tags.
    always_comb begin
        occ_next      = '0;
        overflow_next = overflow_reg;
        count_next    = '0;
        iss_entry     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_next[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_reg[i] && !(fire && sel_idx == IW'(i)) && !(bus.flush && ent_reg[i].tag)) begin
                ent_next[count_next[IW-1:0]] = woke[i];
                occ_next[count_next[IW-1:0]] = 1'b1;
                count_next = count_next + CW'(1);
            end
        end
        if (!bus.flush) begin
            for (int p = 0; p < ISSUE_CNT; p++) begin
                if (bus.iss_valid[p]) begin
                    if (count_next < CW'(DEPTH)) begin
                        iss_entry         = '0;
                        iss_entry.tag     = bus.iss_tag[p];
                        iss_entry.src1    = bus.iss_src1[p*RN_W +: RN_W];
                        iss_entry.src2    = bus.iss_src2[p*RN_W +: RN_W];
                        iss_entry.payload = bus.iss_payload[p*PAY_W +: PAY_W];
                        {iss_entry.ok1, iss_entry.data1} = capture(
                            bus.iss_src1[p*RN_W +: RN_W], bus.iss_ok1[p], bus.iss_data1[p*XLEN +: XLEN],
                            bus.cdb_valid, bus.cdb_rn, bus.cdb_data);
                        {iss_entry.ok2, iss_entry.data2} = capture(
                            bus.iss_src2[p*RN_W +: RN_W], bus.iss_ok2[p], bus.iss_data2[p*XLEN +: XLEN],
                            bus.cdb_valid, bus.cdb_rn, bus.cdb_data);
                        ent_next[count_next[IW-1:0]] = iss_entry;
                        occ_next[count_next[IW-1:0]] = 1'b1;
                        count_next = count_next + CW'(1);
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
            end
        end
        if (bus.tag_clear && !bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_next[i].tag = 1'b0;
            end
        end
    end

    // State registers; reset empties the station without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
            occ_reg        <= '0;
            free_count_reg <= CW'(DEPTH);
            overflow_reg   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= ent_next[i];
            end
            occ_reg        <= occ_next;
            free_count_reg <= CW'(DEPTH) - count_next;
            overflow_reg   <= overflow_next;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus a
// randomized run, all compared each cycle against a queue-based model.
module tb_reservation_station;
    localparam int DEPTH = 16;
    localparam int IC    = 2;
    localparam int CC    = 2;
    localparam int XLEN  = 32;
    localparam int RN_W  = 6;
    localparam int PW    = 72;

    typedef struct {
        logic            tag;
        logic            ok1;
        logic            ok2;
        logic [RN_W-1:0] s1;
        logic [RN_W-1:0] s2;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [PW-1:0]   pay;
    } m_ent_t;

    logic clk;
    logic reset;
    int   cmp_cnt;
    int   err_cnt;

    m_ent_t q[$];
    logic   m_ovf;

    logic            s_valid;
    logic [XLEN-1:0] s_d1;
    logic [XLEN-1:0] s_d2;
    logic [PW-1:0]   s_pay;
    logic            s_tag;

    reservation_station_if #(.DEPTH(DEPTH), .ISSUE_CNT(IC), .CDB_CNT(CC),
                             .XLEN(XLEN), .RN_W(RN_W), .PAY_W(PW)) bus ();

    reservation_station #(.DEPTH(DEPTH), .ISSUE_CNT(IC), .CDB_CNT(CC),
                          .XLEN(XLEN), .RN_W(RN_W), .PAY_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand rule: r0 reads as valid zero, else first matching CDB.
    function automatic logic [XLEN:0] resolve(input logic [RN_W-1:0] s, input logic ok,
                                              input logic [XLEN-1:0] d);
        logic [XLEN:0] r;
        logic          hit;
        r   = {ok, d};
        hit = 1'b0;
        if (s == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end else if (!ok) begin
            for (int c = 0; c < CC; c++) begin
                if (!hit && bus.cdb_valid[c] && bus.cdb_rn[c*RN_W +: RN_W] == s) begin
                    r   = {1'b1, bus.cdb_data[c*XLEN +: XLEN]};
                    hit = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic clear_inputs();
        bus.iss_valid   = '0;
        bus.iss_src1    = '0;
        bus.iss_src2    = '0;
        bus.iss_ok1     = '0;
        bus.iss_ok2     = '0;
        bus.iss_data1   = '0;
        bus.iss_data2   = '0;
        bus.iss_tag     = '0;
        bus.iss_payload = '0;
        bus.cdb_valid   = '0;
        bus.cdb_rn      = '0;
        bus.cdb_data    = '0;
        bus.flush       = 1'b0;
        bus.tag_clear   = 1'b0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic put(input int p, input logic [RN_W-1:0] s1, input logic ok1, input logic [XLEN-1:0] d1,
                       input logic [RN_W-1:0] s2, input logic ok2, input logic [XLEN-1:0] d2,
                       input logic tag, input logic [PW-1:0] pay);
        bus.iss_valid[p]                = 1'b1;
        bus.iss_src1[p*RN_W +: RN_W]    = s1;
        bus.iss_ok1[p]                  = ok1;
        bus.iss_data1[p*XLEN +: XLEN]   = d1;
        bus.iss_src2[p*RN_W +: RN_W]    = s2;
        bus.iss_ok2[p]                  = ok2;
        bus.iss_data2[p*XLEN +: XLEN]   = d2;
        bus.iss_tag[p]                  = tag;
        bus.iss_payload[p*PW +: PW]     = pay;
    endtask

    task automatic cdb(input int c, input logic [RN_W-1:0] rn, input logic [XLEN-1:0] d);
        bus.cdb_valid[c]              = 1'b1;
        bus.cdb_rn[c*RN_W +: RN_W]    = rn;
        bus.cdb_data[c*XLEN +: XLEN]  = d;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, compare status.
    task automatic cycle();
        int     k;
        logic   ev;
        logic   fire;
        m_ent_t nq[$];
        m_ent_t e;
        @(negedge clk);
        s_valid = bus.out_valid;
        s_d1    = bus.out_data1;
        s_d2    = bus.out_data2;
        s_pay   = bus.out_payload;
        s_tag   = bus.out_tag;
        k = -1;
        foreach (q[i]) begin
            if (k < 0 && q[i].ok1 && q[i].ok2) k = i;
        end
        ev = (k >= 0) && !(bus.flush && q[k].tag);
        check("out_valid", 128'(s_valid), 128'(ev));
        if (ev) begin
            check("out_data1",   128'(s_d1),  128'(q[k].d1));
            check("out_data2",   128'(s_d2),  128'(q[k].d2));
            check("out_payload", 128'(s_pay), 128'(q[k].pay));
            check("out_tag",     128'(s_tag), 128'(q[k].tag));
        end
        fire = ev && bus.out_ready;
        if (fire) $display("dispatch t=%0t d1=%h d2=%h tag=%0d pay=%h", $time, s_d1, s_d2, s_tag, s_pay);
        foreach (q[i]) begin
            if (!(fire && i == k) && !(bus.flush && q[i].tag)) begin
                e = q[i];
                {e.ok1, e.d1} = resolve(e.s1, e.ok1, e.d1);
                {e.ok2, e.d2} = resolve(e.s2, e.ok2, e.d2);
                nq.push_back(e);
            end
        end
        if (!bus.flush) begin
            for (int p = 0; p < IC; p++) begin
                if (bus.iss_valid[p]) begin
                    if (nq.size() < DEPTH) begin
                        e.tag = bus.iss_tag[p];
                        e.s1  = bus.iss_src1[p*RN_W +: RN_W];
                        e.s2  = bus.iss_src2[p*RN_W +: RN_W];
                        e.pay = bus.iss_payload[p*PW +: PW];
                        {e.ok1, e.d1} = resolve(e.s1, bus.iss_ok1[p], bus.iss_data1[p*XLEN +: XLEN]);
                        {e.ok2, e.d2} = resolve(e.s2, bus.iss_ok2[p], bus.iss_data2[p*XLEN +: XLEN]);
                        nq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        if (bus.tag_clear && !bus.flush) begin
            foreach (nq[i]) nq[i].tag = 1'b0;
        end
        q = nq;
        @(posedge clk);
        #1;
        check("free_count", 128'(bus.free_count), 128'(DEPTH - q.size()));
        check("overflow",   128'(bus.overflow),   128'(m_ovf));
    endtask

    task automatic drive_random(input int rate);
        clear_inputs();
        for (int p = 0; p < IC; p++) begin
            if ($urandom_range(99) < rate) begin
                put(p, RN_W'($urandom_range(7)), ($urandom_range(9) < 6), $urandom(),
                    RN_W'($urandom_range(7)), ($urandom_range(9) < 6), $urandom(),
                    ($urandom_range(3) == 0), PW'({$urandom(), $urandom(), $urandom()}));
            end
        end
        for (int c = 0; c < CC; c++) begin
            if ($urandom_range(9) < 4) cdb(c, RN_W'($urandom_range(7)), $urandom());
        end
        bus.flush     = ($urandom_range(19) == 0);
        bus.tag_clear = ($urandom_range(9) == 0);
        bus.out_ready = ($urandom_range(9) < 6);
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        m_ovf   = 1'b0;
        reset   = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid",  128'(bus.out_valid),  128'(0));
        check("reset_free_count", 128'(bus.free_count), 128'(16));
        check("reset_overflow",   128'(bus.overflow),   128'(0));
        check("reset_out_data1",  128'(bus.out_data1),  128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ready-at-issue entry dispatches the next cycle.
        put(0, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2, 1'b0, 72'h1);
        cycle();
        check("t031_free_after_issue", 128'(bus.free_count), 128'(15));
        clear_inputs();
        bus.out_ready = 1'b1;
        cycle();
        check("t031_valid", 128'(s_valid), 128'(1));
        check("t031_data1", 128'(s_d1), 128'(32'hA1));
        check("t031_data2", 128'(s_d2), 128'(32'hA2));
        check("t031_free",  128'(bus.free_count), 128'(16));

        // Older waiting entry is overtaken, then woken by the CDB.
        clear_inputs();
        put(0, 6'd5, 1'b0, 32'h0, 6'd3, 1'b1, 32'hA2, 1'b0, 72'h2);
        cycle();
        clear_inputs();
        put(0, 6'd1, 1'b1, 32'hB1, 6'd2, 1'b1, 32'hB2, 1'b0, 72'h3);
        cycle();
        check("t032_a_waits", 128'(s_valid), 128'(0));
        clear_inputs();
        cdb(0, 6'd5, 32'hDEAD);
        bus.out_ready = 1'b1;
        cycle();
        check("t032_b_first", 128'(s_d1), 128'(32'hB1));
        clear_inputs();
        bus.out_ready = 1'b1;
        cycle();
        check("t032_a_valid", 128'(s_valid), 128'(1));
        check("t032_a_data1", 128'(s_d1), 128'(32'hDEAD));

        // Same-cycle CDB capture at issue; lowest CDB index wins.
        clear_inputs();
        put(0, 6'd7, 1'b0, 32'h99, 6'd4, 1'b1, 32'h22, 1'b0, 72'h4);
        cdb(0, 6'd7, 32'h11);
        cdb(1, 6'd7, 32'h33);
        cycle();
        clear_inputs();
        bus.out_ready = 1'b1;
        cycle();
        check("t033_valid", 128'(s_valid), 128'(1));
        check("t033_data1", 128'(s_d1), 128'(32'h11));

        // Fill, overflow, then full with same-edge dispatch.
        for (int n = 0; n < DEPTH / 2; n++) begin
            clear_inputs();
            put(0, 6'd1, 1'b1, 32'h1000 + 32'(2*n), 6'd2, 1'b1, 32'h2000, 1'b0, 72'h10);
            put(1, 6'd1, 1'b1, 32'h1001 + 32'(2*n), 6'd2, 1'b1, 32'h2000, 1'b0, 72'h11);
            cycle();
        end
        check("t034_full_free", 128'(bus.free_count), 128'(0));
        check("t034_no_ovf_yet", 128'(bus.overflow), 128'(0));
        clear_inputs();
        put(0, 6'd1, 1'b1, 32'h3000, 6'd2, 1'b1, 32'h3000, 1'b0, 72'h12);
        put(1, 6'd1, 1'b1, 32'h3001, 6'd2, 1'b1, 32'h3001, 1'b0, 72'h13);
        cycle();
        check("t034_ovf", 128'(bus.overflow), 128'(1));
        check("t034_free", 128'(bus.free_count), 128'(0));
        clear_inputs();
        put(0, 6'd1, 1'b1, 32'h4000, 6'd2, 1'b1, 32'h4000, 1'b0, 72'h14);
        put(1, 6'd1, 1'b1, 32'h4001, 6'd2, 1'b1, 32'h4001, 1'b0, 72'h15);
        bus.out_ready = 1'b1;
        cycle();
        check("t034_oldest_out", 128'(s_d1), 128'(32'h1000));
        for (int n = 0; n < 11; n++) begin
            clear_inputs();
            bus.out_ready = 1'b1;
            cycle();
        end
        check("t034_drained", 128'(bus.free_count), 128'(11));

        // Asynchronous reset with five entries held.
        clear_inputs();
        #2;
        check("t036_valid_before", 128'(bus.out_valid), 128'(1));
        reset = 1'b0;
        #1;
        check("t036_valid",    128'(bus.out_valid),  128'(0));
        check("t036_free",     128'(bus.free_count), 128'(16));
        check("t036_overflow", 128'(bus.overflow),   128'(0));
        check("t036_data1",    128'(bus.out_data1),  128'(0));
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Flush with a tagged oldest entry.
        clear_inputs();
        put(0, 6'd1, 1'b1, 32'h71, 6'd2, 1'b1, 32'h72, 1'b1, 72'h20);
        put(1, 6'd1, 1'b1, 32'h51, 6'd2, 1'b1, 32'h52, 1'b0, 72'h21);
        cycle();
        clear_inputs();
        put(0, 6'd1, 1'b1, 32'h81, 6'd2, 1'b1, 32'h82, 1'b1, 72'h22);
        cycle();
        clear_inputs();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        check("t035_suppressed", 128'(s_valid), 128'(0));
        check("t035_free", 128'(bus.free_count), 128'(15));
        clear_inputs();
        cycle();
        check("t035_u1_valid", 128'(s_valid), 128'(1));
        check("t035_u1_data",  128'(s_d1), 128'(32'h51));
        check("t035_u1_tag",   128'(s_tag), 128'(0));
        clear_inputs();
        bus.out_ready = 1'b1;
        cycle();

        // Randomized traffic, alternating light and heavy issue phases.
        for (int n = 0; n < 1500; n++) begin
            drive_random(((n / 250) % 2 == 1) ? 15 : 45);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
